pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 82 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush controller for load-use, multi-cycle EX and redirects
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        ex_mc_start_i,
  input  logic [5:0]  ex_mc_cycles_i,
  input  logic        flush_req_i,
  input  logic [31:0] flush_pc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o,
  output logic [31:0] stall_cycles_o
);
  typedef enum logic [1:0] {RUN, MC_STALL, FLUSH} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] stall_cycles_q;
  logic [5:0]  stall_d;
  logic        flush_d;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    stall_d  = 6'b000000;
    flush_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_req_i) begin
          flush_d  = 1'b1;
          new_pc_d = flush_pc_i;
          state_d  = FLUSH;
        end else if (ex_mc_start_i && ex_mc_cycles_i != 6'd0) begin
          stall_d = 6'b001111;
          if (ex_mc_cycles_i != 6'd1) begin
            cnt_d   = ex_mc_cycles_i - 6'd1;
            state_d = MC_STALL;
          end
        end else if (stallreq_id_i) begin
          stall_d = 6'b000111;
        end
      end
      MC_STALL: begin
        if (flush_req_i) begin
          flush_d  = 1'b1;
          cnt_d    = 6'd0;
          new_pc_d = flush_pc_i;
          state_d  = FLUSH;
        end else begin
          stall_d = 6'b001111;
          cnt_d   = cnt_q - 6'd1;
          state_d = (cnt_q <= 6'd1) ? RUN : MC_STALL;
        end
      end
      default: begin
        flush_d  = 1'b1;
        new_pc_d = flush_req_i ? flush_pc_i : new_pc_q;
        state_d  = flush_req_i ? FLUSH : RUN;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      cnt_q          <= 6'd0;
      new_pc_q       <= 32'h0;
      stall_cycles_q <= 32'h0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      new_pc_q       <= new_pc_d;
      stall_cycles_q <= (|stall_d && ~&stall_cycles_q) ? stall_cycles_q + 32'd1 : stall_cycles_q;
    end
  end
  assign stall_o        = rst ? 6'b000000 : stall_d;
  assign flush_o        = rst ? 1'b0 : flush_d;
  assign new_pc_o       = new_pc_q;
  assign busy_o         = state_q != RUN;
  assign stall_cycles_o = stall_cycles_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with directed scenarios and random traffic vs a cycle-budget model
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id_i = 1'b0;
  logic        ex_mc_start_i = 1'b0;
  logic [5:0]  ex_mc_cycles_i = 6'd0;
  logic        flush_req_i = 1'b0;
  logic [31:0] flush_pc_i = 32'h0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;
  logic [31:0] stall_cycles_o;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .stallreq_id_i(stallreq_id_i), .ex_mc_start_i(ex_mc_start_i),
    .ex_mc_cycles_i(ex_mc_cycles_i), .flush_req_i(flush_req_i), .flush_pc_i(flush_pc_i),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o), .busy_o(busy_o),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic        busy;
    logic [31:0] pc;
    logic [31:0] scnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   done = 1'b0;

  // Model: stall cycles still owed by a multi-cycle op, whether a flush cycle is owed, captured PC, stall tally
  int          owed = 0;
  bit          in_flush = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_scnt = 32'h0;

  task automatic cycle(input bit r, input bit sid, input bit st, input int n, input bit fr, input logic [31:0] fpc);
    exp_t e;
    @(negedge clk);
    rst = r; stallreq_id_i = sid; ex_mc_start_i = st; ex_mc_cycles_i = 6'(n);
    flush_req_i = fr; flush_pc_i = fpc;
    e.pc = m_pc; e.scnt = m_scnt; e.busy = (owed > 0) || in_flush;
    e.stall = 6'b0; e.flush = 1'b0;
    if (r) begin
      owed = 0; in_flush = 0; m_pc = 0; m_scnt = 0;
    end else begin
      if (fr) begin
        e.flush = 1'b1; m_pc = fpc; in_flush = 1; owed = 0;
      end else if (in_flush) begin
        e.flush = 1'b1; in_flush = 0;
      end else if (owed > 0) begin
        e.stall = 6'b001111; owed--;
      end else if (st && n > 0) begin
        e.stall = 6'b001111; owed = n - 1;
      end else if (sid) begin
        e.stall = 6'b000111;
      end
      if (e.stall != 0 && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall_o", 32'(stall_o), 32'(e.stall));
        chk("flush_o", 32'(flush_o), 32'(e.flush));
        chk("busy_o", 32'(busy_o), 32'(e.busy));
        chk("new_pc_o", new_pc_o, e.pc);
        chk("stall_cycles_o", stall_cycles_o, e.scnt);
        cyc++;
      end
    end
  end

  initial begin : stim
    @(posedge clk);
    cycle(1, 1, 1, 5, 1, 32'hDEAD_BEEF);
    cycle(1, 0, 0, 0, 0, 32'h0);
    idle(1);
    cycle(0, 1, 0, 0, 0, 32'h0);
    idle(1);
    cycle(0, 0, 1, 5, 0, 32'h0);
    idle(6);
    cycle(0, 0, 1, 1, 0, 32'h0);
    idle(1);
    cycle(0, 1, 1, 0, 0, 32'h0);
    idle(1);
    cycle(0, 0, 1, 10, 0, 32'h0);
    cycle(0, 1, 1, 3, 0, 32'h0);
    cycle(0, 0, 0, 0, 1, 32'h0000_0100);
    idle(3);
    cycle(0, 1, 1, 4, 1, 32'h0000_0200);
    idle(2);
    cycle(0, 0, 1, 10, 0, 32'h0);
    idle(2);
    cycle(1, 1, 1, 3, 1, 32'h0000_0300);
    idle(2);
    cycle(0, 0, 0, 0, 1, 32'h0000_0400);
    cycle(0, 0, 0, 0, 1, 32'h0000_0500);
    idle(2);
    cycle(0, 0, 1, 63, 0, 32'h0);
    idle(64);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 12), $urandom_range(0, 29) == 0, $urandom);
    idle(1);
    repeat (3) @(negedge clk);
    #5;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
